data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

Parametrised data-memory block for the pipelined MIPS core. It replaces the fixed-size, combinational-read data RAM with a byte-addressed memory that has a request/response handshake, a configurable read latency and response backpressure. It also handles MIPS load/store sizing (byte/half/word), sign or zero extension, and alignment/range error reporting. It sits between the MEM stage and the physical storage array.

## Interface
- DEPTH, 1024, number of 32-bit words; word index = req_addr[31:2].
- RD_LAT, 1, read latency in cycles, legal range 1..4.
- INIT_FILE, "", hex image loaded with $readmemh at initialisation; empty string means no preload.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request may be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result after extension; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.

## Operation
- Accept condition: req_valid & req_ready at a rising edge. Every accepted request, load or store, produces exactly one response.
- Responses are returned in acceptance order.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], and lane = req_addr[1:0].
- Store data replication:
  - byte: {4{wdata[7:0]}}, write enable = lane k only.
  - half: {2{wdata[15:0]}}, write enable = lanes 1:0 or 3:2.
  - word: all four lanes.
- Stores commit to the array at the accept edge.
- Loads read the array at the accept edge, then extract and extend:
  - byte: selected lane.
  - half: addr[1] ? [31:16] : [15:0].
  - word: full 32 bits.
- Error conditions:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - size 11.
  - addr[31:2] ≥ DEPTH.
- On error: no array write, rsp_err=1, rsp_rdata=0.
- Read pipeline: RD_LAT-1 registered stages after the sampling edge, feeding a response FIFO of depth RD_LAT+1.
- Credit counter cnt (0..RD_LAT+1) tracks in-flight plus buffered responses:
  - +1 on accept, -1 on response pop (rsp_valid & rsp_ready).
  - Both in the same cycle: cnt unchanged.
- req_ready = resetn & (cnt < RD_LAT+1). The FIFO therefore never overflows.
- rsp_valid = FIFO non-empty. rsp_rdata and rsp_err come from the FIFO head and stay stable while rsp_valid & !rsp_ready.
- Array contents are not reset; only control state is.

## Timing
- Reset (resetn low, asynchronous):
  - Cleared: cnt, pipeline valid bits, FIFO pointers.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- Reset mid-operation: in-flight and buffered responses are dropped. Stores committed before reset persist.
- Accept at edge N → response valid from edge N+RD_LAT-1, provided the FIFO was empty or is draining. RD_LAT=1 behaves as a registered read.
- Back-to-back requests:
  - A load accepted at edge N+1 observes a store accepted at edge N.
  - With rsp_ready held high, throughput is 1 request/cycle for any RD_LAT.
- Backpressure: with rsp_ready low, at most RD_LAT+1 requests are accepted; req_ready then stays low until the first pop.
- Pointer wrap-around is modulo FIFO depth; full and empty are distinguished by cnt.

## Test plan
- Reset: hold resetn low → req_ready=0, rsp_valid=0, rsp_rdata=0; release → req_ready=1 on the next cycle.
- sw 0xDEADBEEF @0x10, then lw @0x10 (RD_LAT=1 and RD_LAT=3) → rsp_rdata=0xDEADBEEF, rsp_err=0, latency exactly RD_LAT.
- Sizing, all after the store above:
  - lb @0x11 → 0xFFFFFFBE.
  - lbu @0x11 → 0x000000BE.
  - lh @0x12 → 0xFFFFDEAD.
  - sb 0x5A @0x13, then lw @0x10 → 0x5AADBEEF.
- Errors:
  - lw @0x12 → rsp_err=1, rdata=0.
  - sh @0x11 → rsp_err=1, and a following lw @0x10 is unchanged.
  - lw @(DEPTH*4) → rsp_err=1.
- Backpressure: RD_LAT=3, rsp_ready=0, eight loads of distinct words issued → only 4 accepted, req_ready low. Raise rsp_ready → the 4 responses come out in order, then the remaining 4 are accepted and returned; no loss or duplication.
- Reset mid-operation: 2 loads in flight, pulse resetn → no responses after release; an earlier committed store still reads back correctly.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Byte-addressed MIPS data memory with request/response handshake, configurable
// read latency, load/store sizing with extension, and alignment/range error reporting.
module data_ram_ctrl #(
  parameter int    DEPTH     = 1024,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int FD = RD_LAT + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        is_load;
    logic        err;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] word;
  } ent_t;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready. Neither
  // ready depends combinationally on its own valid.
  logic          accept;
  logic          pop;
  logic          fifo_empty;
  logic          req_err;
  logic          out_of_range;
  logic [AW-1:0] word_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  ent_t          in_ent;
  logic          push_vld;
  ent_t          push_ent;

  logic [31:0]   mem_q [DEPTH];

  ent_t          fifo_q [FD];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign accept       = req_valid && req_ready;
  assign pop          = rsp_valid && rsp_ready;
  assign req_ready    = resetn && (cnt_q < CW'(FD));
  assign word_idx     = req_addr[AW+1:2];
  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (out_of_range) req_err = 1'b1;
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (req_size)
      2'b00: begin
        wr_data = {4{req_wdata[7:0]}};
        wr_be   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wr_data = {2{req_wdata[15:0]}};
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
    if (!(accept && req_we) || req_err) wr_be = 4'b0000;
  end

  // Storage array is deliberately not reset; stores survive a control reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  always_comb begin
    in_ent.is_load = !req_we;
    in_ent.err     = req_err;
    in_ent.size    = req_size;
    in_ent.sgn     = req_signed;
    in_ent.lane    = req_addr[1:0];
    in_ent.word    = mem_q[word_idx];
  end

  // The sampling edge is the first register; RD_LAT-1 more stages feed the FIFO.
  if (RD_LAT == 1) begin : g_nopipe
    assign push_vld = accept;
    assign push_ent = in_ent;
  end else begin : g_pipe
    localparam int NS = RD_LAT - 1;
    logic [NS-1:0] vld_q;
    ent_t          ent_q [NS];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < NS; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= in_ent;
      for (int i = 1; i < NS; i++) ent_q[i] <= ent_q[i-1];
    end

    assign push_vld = vld_q[NS-1];
    assign push_ent = ent_q[NS-1];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Equal pointers mean full only when every credit sits in the FIFO.
  assign fifo_empty = (rptr_q == wptr_q) && (cnt_q != CW'(FD));
  assign rsp_valid  = !fifo_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_vld) wptr_d = ptr_inc(wptr_q);
    if (pop)      rptr_d = ptr_inc(rptr_q);
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) fifo_q[wptr_q] <= push_ent;
  end

  ent_t        head;
  logic [7:0]  head_byte;
  logic [15:0] head_half;
  logic [31:0] head_rdata;

  assign head = fifo_q[rptr_q];

  always_comb begin
    head_byte = head.word[7:0];
    case (head.lane)
      2'b00:   head_byte = head.word[7:0];
      2'b01:   head_byte = head.word[15:8];
      2'b10:   head_byte = head.word[23:16];
      default: head_byte = head.word[31:24];
    endcase
    head_half  = head.lane[1] ? head.word[31:16] : head.word[15:0];
    head_rdata = '0;
    if (head.is_load && !head.err) begin
      case (head.size)
        2'b00:   head_rdata = head.sgn ? {{24{head_byte[7]}}, head_byte} : {24'h0, head_byte};
        2'b01:   head_rdata = head.sgn ? {{16{head_half[15]}}, head_half} : {16'h0, head_half};
        2'b10:   head_rdata = head.word;
        default: head_rdata = '0;
      endcase
    end
  end

  assign rsp_rdata = rsp_valid ? head_rdata : '0;
  assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3.
module tb_data_ram_ctrl;

  localparam int DEPTH = 256;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_ready, req_we, req_signed;
  logic [1:0]  rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic        collect = 1'b0;
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (collect && rsp_valid[1] && rsp_ready[1]) got_q.push_back({rsp_err[1], rsp_rdata[1]});
  end

  data_ram_ctrl #(.DEPTH(DEPTH), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_ram_ctrl #(.DEPTH(DEPTH), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%09h expected=%09h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int d, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_size[d]   = size;
    req_signed[d] = sgn;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 33'(n < 40), 33'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                     input logic [31:0] exp_rd, input logic exp_err, output int lat);
    logic [31:0] rd;
    logic        er;
    issue(d, we, size, sgn, addr, wdata);
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_in_time"}, 33'(lat < 20), 33'(1));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    chk({tag, "_rdata"}, 33'(rd), 33'(exp_rd));
    chk({tag, "_err"}, 33'(er), 33'(exp_err));
    @(negedge clk);
  endtask

  task automatic check_queue(input string tag, input int expected_n);
    int n;
    n = 0;
    while (got_q.size() < expected_n && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_count"}, 33'(got_q.size()), 33'(expected_n));
    for (int i = 0; i < expected_n; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        chk($sformatf("%s_rsp%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;
    resetn     = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_signed = '0;
    rsp_ready  = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_size[d]  = SZ_W;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready_%0d", d), 33'(req_ready[d]), 33'(0));
      chk($sformatf("rst_rsp_valid_%0d", d), 33'(rsp_valid[d]), 33'(0));
      chk($sformatf("rst_rsp_rdata_%0d", d), 33'(rsp_rdata[d]), 33'(0));
      chk($sformatf("rst_rsp_err_%0d", d), 33'(rsp_err[d]), 33'(0));
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_req_ready_0", 33'(req_ready[0]), 33'(1));
    chk("rel_req_ready_1", 33'(req_ready[1]), 33'(1));

    // Store/load round trip and latency on both instances.
    txn(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, "sw_l1", 32'h0, 1'b0, lat);
    txn(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "lw_l1", 32'hDEADBEEF, 1'b0, lat);
    chk("lw_l1_latency", 33'(lat), 33'(1));
    txn(1, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, "sw_l3", 32'h0, 1'b0, lat);
    txn(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "lw_l3", 32'hDEADBEEF, 1'b0, lat);
    chk("lw_l3_latency", 33'(lat), 33'(3));

    // Load sizing and extension.
    txn(0, 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, "lb_11", 32'hFFFFFFBE, 1'b0, lat);
    txn(0, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, "lbu_11", 32'h000000BE, 1'b0, lat);
    txn(0, 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, "lh_12", 32'hFFFFDEAD, 1'b0, lat);
    txn(0, 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, "lhu_10", 32'h0000BEEF, 1'b0, lat);
    txn(0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h0000005A, "sb_13", 32'h0, 1'b0, lat);
    txn(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "lw_after_sb", 32'h5AADBEEF, 1'b0, lat);
    txn(0, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, "lb_13", 32'h0000005A, 1'b0, lat);

    // Error cases.
    txn(0, 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, "lw_misalign", 32'h0, 1'b1, lat);
    txn(0, 1'b1, SZ_H, 1'b0, 32'h11, 32'h00001234, "sh_misalign", 32'h0, 1'b1, lat);
    txn(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "lw_after_bad_sh", 32'h5AADBEEF, 1'b0, lat);
    txn(0, 1'b0, SZ_W, 1'b0, DEPTH * 4, 32'h0, "lw_range", 32'h0, 1'b1, lat);
    txn(0, 1'b0, SZ_X, 1'b0, 32'h10, 32'h0, "ld_size11", 32'h0, 1'b1, lat);
    txn(1, 1'b1, SZ_W, 1'b0, DEPTH * 4 + 32'h10, 32'h0, "sw_range_l3", 32'h0, 1'b1, lat);
    txn(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "lw_l3_unchanged", 32'hDEADBEEF, 1'b0, lat);

    // Back-to-back requests: full throughput, load observes the preceding store.
    got_q.delete();
    exp_q.delete();
    collect = 1'b1;
    c0 = cyc;
    issue(1, 1'b1, SZ_W, 1'b0, 32'h20, 32'h13579BDF);
    issue(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    issue(1, 1'b0, SZ_B, 1'b1, 32'h21, 32'h0);
    issue(1, 1'b0, SZ_H, 1'b0, 32'h22, 32'h0);
    chk("b2b_cycles", 33'(cyc - c0), 33'(4));
    exp_q.push_back({1'b0, 32'h00000000});
    exp_q.push_back({1'b0, 32'h13579BDF});
    exp_q.push_back({1'b0, 32'hFFFFFF9B});
    exp_q.push_back({1'b0, 32'h00001357});
    check_queue("b2b", 4);
    collect = 1'b0;

    // Backpressure on the RD_LAT=3 instance.
    for (int i = 0; i < 8; i++)
      txn(1, 1'b1, SZ_W, 1'b0, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i), "bp_fill", 32'h0, 1'b0, lat);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 32'hA0000000 + 32'(i)});
    collect      = 1'b1;
    rsp_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) issue(1, 1'b0, SZ_W, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
    chk("bp_ready_low", 33'(req_ready[1]), 33'(0));
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_size[1]  = SZ_W;
    req_addr[1]  = 32'h50;
    repeat (6) @(negedge clk);
    chk("bp_ready_still_low", 33'(req_ready[1]), 33'(0));
    chk("bp_rsp_valid", 33'(rsp_valid[1]), 33'(1));
    chk("bp_head_stable", 33'(rsp_rdata[1]), 33'(32'hA0000000));
    chk("bp_nothing_popped", 33'(got_q.size()), 33'(0));
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    @(negedge clk);
    for (int i = 4; i < 8; i++) issue(1, 1'b0, SZ_W, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
    check_queue("bp", 8);
    collect = 1'b0;

    // Reset with two loads in flight.
    got_q.delete();
    collect = 1'b1;
    issue(1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
    issue(1, 1'b0, SZ_W, 1'b0, 32'h44, 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 33'(rsp_valid[1]), 33'(0));
    chk("midrst_req_ready", 33'(req_ready[1]), 33'(0));
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_rsp", 33'(got_q.size()), 33'(0));
    collect = 1'b0;
    txn(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "midrst_lw_l3", 32'hDEADBEEF, 1'b0, lat);
    txn(1, 1'b0, SZ_W, 1'b0, 32'h44, 32'h0, "midrst_lw44_l3", 32'hA0000001, 1'b0, lat);
    txn(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "midrst_lw_l1", 32'h5AADBEEF, 1'b0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
